// File: rtl/scan_pkg.sv
// Shared types and constants for the LED select generator and its prescaler.
package scan_pkg;

  localparam int               SEL_W   = 5;
  localparam logic [SEL_W-1:0] SEL_MAX = 5'd31;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PP   = 2'b10,
    MODE_ONE  = 2'b11
  } mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate divider: counts 0..PRESCALE-1 while enabled and flags the terminal count.
// tick is decoded from the count register; clr wins over counting and masks tick.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = cnt_en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_sel_gen.sv
// Select/enable generator for the 32-output LED decoder: up, down, ping-pong or single-shot
// stepping at a prescaled rate. All outputs are registered.
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             wrap,
  output logic             busy
);

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic             dir_q;
  logic             en_q;
  logic             busy_q;
  logic             wrap_q;

  logic [SEL_W-1:0] step_sel_d;
  logic             step_dir_d;
  logic             step_wrap_d;
  logic             step_done_d;
  logic             tick;
  logic             presc_clr;
  logic             presc_en;
  mode_e            mode_s;

  assign mode_s    = mode_e'(mode);
  assign presc_clr = load || (state_q != SCAN);
  assign presc_en  = (state_q == SCAN) && run;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (presc_clr),
    .cnt_en (presc_en),
    .tick   (tick)
  );

  // Candidate next select for a step; mode is sampled here so a change lands on the next step.
  always_comb begin
    step_sel_d  = sel_q;
    step_dir_d  = dir_q;
    step_wrap_d = 1'b0;
    step_done_d = 1'b0;
    case (mode_s)
      MODE_UP: begin
        step_sel_d  = sel_q + SEL_W'(1);
        step_wrap_d = (sel_q == SEL_MAX);
      end
      MODE_DOWN: begin
        step_sel_d  = sel_q - SEL_W'(1);
        step_wrap_d = (sel_q == '0);
      end
      MODE_PP: begin
        if (dir_q == DIR_UP) begin
          if (sel_q == SEL_MAX) begin
            step_sel_d  = SEL_MAX - SEL_W'(1);
            step_dir_d  = DIR_DN;
            step_wrap_d = 1'b1;
          end else begin
            step_sel_d = sel_q + SEL_W'(1);
          end
        end else begin
          if (sel_q == '0) begin
            step_sel_d  = SEL_W'(1);
            step_dir_d  = DIR_UP;
            step_wrap_d = 1'b1;
          end else begin
            step_sel_d = sel_q - SEL_W'(1);
          end
        end
      end
      default: begin
        if (sel_q == SEL_MAX) begin
          step_done_d = 1'b1;
          step_wrap_d = 1'b1;
        end else begin
          step_sel_d = sel_q + SEL_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dir_q   <= DIR_UP;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (load) begin
        sel_q <= load_val;
        dir_q <= DIR_UP;
      end
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q <= SCAN;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          // Dropping run discards any step due on this edge.
          if (!run) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tick && !load) begin
            sel_q  <= step_sel_d;
            dir_q  <= step_dir_d;
            wrap_q <= step_wrap_d;
            if (step_done_d) begin
              state_q <= DONE;
              en_q    <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (!run || load) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Directed bench: one instance at PRESCALE=1 for sequencing, one at PRESCALE=4 for rate and tick collisions.
module tb_scan_sel_gen;
  import scan_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       run1, load1, run4, load4;
  logic [1:0] mode1, mode4;
  logic [4:0] lv1, lv4;
  logic [4:0] sel1, sel4;
  logic       en1, wrap1, busy1, en4, wrap4, busy4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       run;
    logic [1:0] mode;
    logic       load;
    logic [4:0] lv;
    logic [4:0] sel;
    logic       en;
    logic       wrap;
    logic       busy;
  } vec_t;

  vec_t tbl[29];

  scan_sel_gen #(.PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1), .mode(mode1), .load(load1), .load_val(lv1),
    .sel(sel1), .en(en1), .wrap(wrap1), .busy(busy1)
  );

  scan_sel_gen #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .run(run4), .mode(mode4), .load(load4), .load_val(lv4),
    .sel(sel4), .en(en4), .wrap(wrap4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // act/exp packed as {sel, en, wrap, busy}
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got sel=%0d en=%b wrap=%b busy=%b, want sel=%0d en=%b wrap=%b busy=%b",
               nm, act[7:3], act[2], act[1], act[0], exp[7:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    //            run   mode       load  lv     sel    en    wrap  busy
    tbl[0]  = '{1'b1, MODE_PP,   1'b1, 5'd29, 5'd29, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, MODE_PP,   1'b0, 5'd0,  5'd30, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, MODE_PP,   1'b0, 5'd0,  5'd31, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, MODE_PP,   1'b0, 5'd0,  5'd30, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, MODE_PP,   1'b0, 5'd0,  5'd29, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, MODE_UP,   1'b0, 5'd0,  5'd30, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, MODE_PP,   1'b0, 5'd0,  5'd29, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, MODE_PP,   1'b1, 5'd10, 5'd10, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, MODE_PP,   1'b0, 5'd0,  5'd11, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, MODE_PP,   1'b0, 5'd0,  5'd11, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, MODE_ONE,  1'b1, 5'd30, 5'd30, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, MODE_ONE,  1'b0, 5'd0,  5'd30, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, MODE_ONE,  1'b0, 5'd0,  5'd31, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, MODE_ONE,  1'b0, 5'd0,  5'd31, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, MODE_ONE,  1'b0, 5'd0,  5'd31, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, MODE_ONE,  1'b0, 5'd0,  5'd31, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, MODE_UP,   1'b1, 5'd5,  5'd5,  1'b1, 1'b0, 1'b1};
    tbl[17] = '{1'b1, MODE_UP,   1'b0, 5'd0,  5'd6,  1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b1, MODE_DOWN, 1'b0, 5'd0,  5'd5,  1'b1, 1'b0, 1'b1};
    tbl[19] = '{1'b1, MODE_DOWN, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1};
    tbl[20] = '{1'b1, MODE_DOWN, 1'b0, 5'd0,  5'd31, 1'b1, 1'b1, 1'b1};
    tbl[21] = '{1'b1, MODE_DOWN, 1'b0, 5'd0,  5'd30, 1'b1, 1'b0, 1'b1};
    tbl[22] = '{1'b1, MODE_ONE,  1'b1, 5'd31, 5'd31, 1'b1, 1'b0, 1'b1};
    tbl[23] = '{1'b1, MODE_ONE,  1'b0, 5'd0,  5'd31, 1'b0, 1'b1, 1'b0};
    tbl[24] = '{1'b1, MODE_ONE,  1'b1, 5'd3,  5'd3,  1'b0, 1'b0, 1'b0};
    tbl[25] = '{1'b1, MODE_UP,   1'b0, 5'd0,  5'd3,  1'b1, 1'b0, 1'b1};
    tbl[26] = '{1'b1, MODE_UP,   1'b0, 5'd0,  5'd4,  1'b1, 1'b0, 1'b1};
    tbl[27] = '{1'b1, MODE_PP,   1'b1, 5'd31, 5'd31, 1'b1, 1'b0, 1'b1};
    tbl[28] = '{1'b1, MODE_PP,   1'b0, 5'd0,  5'd30, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    run1 = 1'b1; mode1 = MODE_UP; load1 = 1'b0; lv1 = 5'd0;
    run4 = 1'b0; mode4 = MODE_UP; load4 = 1'b0; lv4 = 5'd0;

    #2;
    chk("reset1", {sel1, en1, wrap1, busy1}, 8'h00);
    chk("reset4", {sel4, en4, wrap4, busy4}, 8'h00);
    #1 rst_n = 1'b1;

    // Up scan at one step per cycle: SCAN entry, then 0..31 and wrap back to 0.
    for (int k = 1; k <= 33; k++) begin
      step();
      chk($sformatf("up%0d", k), {sel1, en1, wrap1, busy1},
          {5'((k - 1) % 32), 1'b1, (k == 33), 1'b1});
    end

    for (int i = 0; i < 29; i++) begin
      run1 = tbl[i].run; mode1 = tbl[i].mode; load1 = tbl[i].load; lv1 = tbl[i].lv;
      step();
      chk($sformatf("vec%0d", i), {sel1, en1, wrap1, busy1},
          {tbl[i].sel, tbl[i].en, tbl[i].wrap, tbl[i].busy});
    end
    load1 = 1'b0;

    // Down scan with PRESCALE=4 from a preset of 2.
    mode4 = MODE_DOWN; load4 = 1'b1; lv4 = 5'd2;
    step();
    chk("dn_load", {sel4, en4, wrap4, busy4}, {5'd2, 1'b0, 1'b0, 1'b0});
    load4 = 1'b0; run4 = 1'b1;
    step();
    chk("dn_entry", {sel4, en4, wrap4, busy4}, {5'd2, 1'b1, 1'b0, 1'b1});
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("dn%0d", k), {sel4, en4, wrap4, busy4},
          {(k < 4) ? 5'd2 : (k < 8) ? 5'd1 : (k < 12) ? 5'd0 : 5'd31, 1'b1, (k == 12), 1'b1});
    end
    // Next edge would be a step; dropping run there must discard it.
    run4 = 1'b0;
    step();
    chk("stop_on_tick", {sel4, en4, wrap4, busy4}, {5'd31, 1'b0, 1'b0, 1'b0});
    run4 = 1'b1;
    step();
    chk("restart", {sel4, en4, wrap4, busy4}, {5'd31, 1'b1, 1'b0, 1'b1});
    step(); step(); step();
    // Load lands on the tick edge: no step, prescaler restarts from zero.
    load4 = 1'b1; lv4 = 5'd17;
    step();
    chk("load_on_tick", {sel4, en4, wrap4, busy4}, {5'd17, 1'b1, 1'b0, 1'b1});
    load4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("after_load%0d", k), {sel4, en4, wrap4, busy4},
          {(k < 4) ? 5'd17 : 5'd16, 1'b1, 1'b0, 1'b1});
    end

    // Asynchronous reset mid-scan at sel=12.
    mode1 = MODE_UP; load1 = 1'b1; lv1 = 5'd10; run1 = 1'b1;
    step();
    chk("pre_rst10", {sel1, en1, wrap1, busy1}, {5'd10, 1'b1, 1'b0, 1'b1});
    load1 = 1'b0;
    step();
    step();
    chk("pre_rst12", {sel1, en1, wrap1, busy1}, {5'd12, 1'b1, 1'b0, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst1", {sel1, en1, wrap1, busy1}, 8'h00);
    chk("async_rst4", {sel4, en4, wrap4, busy4}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_entry", {sel1, en1, wrap1, busy1}, {5'd0, 1'b1, 1'b0, 1'b1});
    step();
    chk("post_rst_step", {sel1, en1, wrap1, busy1}, {5'd1, 1'b1, 1'b0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_sel_gen.md
# scan_sel_gen

Registered select generator feeding the 32-output LED decoder. Produces the 5-bit select (x4..x0) and the decoder enable, stepping the lit output through the 32 positions in up, down, ping-pong or single-shot order at a prescaled rate. Sits directly upstream of the decoder tree; its `sel` bits drive the decoder select inputs and `en` gates the top-level 3-to-8 stage so that all 32 outputs are dark when `en` is low.

## Interface
- `PRESCALE`, default 4: clock cycles per step, legal range 1..256. A value of 1 means a step every cycle.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `run` in 1: level; 1 = scan, 0 = stop or hold.
- `mode` in 2: 00 up, 01 down, 10 ping-pong, 11 single-shot up.
- `load` in 1: one-cycle strobe that loads `load_val`.
- `load_val` in 5: preset value for `sel`.
- `sel` out 5: decoder select; bit 4 is x4, bit 0 is x0.
- `en` out 1: decoder enable.
- `wrap` out 1: one-cycle pulse at each wrap, reversal or single-shot end.
- `busy` out 1: high while in SCAN.

## Operation
- States:
  - IDLE: `en`=0, `sel` held.
  - SCAN: `en`=1, `sel` steps.
  - DONE: `en`=0, `sel`=31.
- Transitions:
  - IDLE→SCAN when `run`=1.
  - SCAN→IDLE when `run`=0; `sel` retained.
  - SCAN→DONE on the single-shot terminal step.
  - DONE→IDLE when `run`=0.
- Prescaler counts 0..PRESCALE-1 in SCAN only. It is cleared on SCAN entry, on `load`, and in IDLE/DONE. A step occurs on the cycle the count equals PRESCALE-1, and the count returns to 0 on that cycle.
- Step rules:
  - Up: `sel`+1 mod 32; `wrap` on 31→0.
  - Down: `sel`-1 mod 32; `wrap` on 0→31.
  - Ping-pong: `dir` register moves `sel` by ±1.
    - At 31 with `dir` up: `sel`→30, `dir`→down, `wrap`=1.
    - At 0 with `dir` down: `sel`→1, `dir`→up, `wrap`=1.
  - Single-shot: `sel`+1 while `sel`<31. A step taken at 31 keeps `sel`=31, enters DONE and sets `wrap`=1.
- `load`:
  - Sets `sel`=`load_val`, `dir`=up, prescaler=0, and suppresses that cycle's step.
  - In DONE, forces IDLE; it is accepted in every state.
  - `load` and `run` rising together: IDLE→SCAN and the load both take effect in the same cycle.
- A `mode` change while in SCAN takes effect at the next step. `dir` is retained across mode changes and is used only in ping-pong.

## Timing
- Reset values: `sel`=0, `en`=0, `wrap`=0, `busy`=0, `dir`=up, state IDLE, prescaler 0.
- All outputs are registered; no combinational input→output paths.
- `run` high at edge N gives `en`=`busy`=1 after edge N. The first step lands PRESCALE edges later, then one step every PRESCALE edges.
- `run` low gives `en`=0 one edge later. A step coinciding with that edge is discarded.
- `wrap` is high for exactly one cycle, in the same cycle `sel` shows its new value.
- Reset asserted mid-scan clears all outputs immediately; no step is taken on the first edge after release.

## Structure
- Shared package `scan_pkg`:
  - State enum: IDLE, SCAN, DONE.
  - Mode encodings: MODE_UP, MODE_DOWN, MODE_PP, MODE_ONE.
  - Constants SEL_W=5 and SEL_MAX=31.
- Sub-module `tick_prescaler`:
  - Parameter PRESCALE.
  - Inputs: `clk`, `rst_n`, `clr`, `cnt_en`.
  - Output: `tick`.
- Top level holds the FSM, `sel`/`dir` registers and wrap logic.

## Test plan
- Reset and up scan:
  - Stimulus: PRESCALE=1, mode up, `run`=1 from reset.
  - Required response: `en`=1 after 1 edge; `sel` then steps 0,1,…,31,0; `wrap` high only in the cycle `sel`=0 after 31.
- Down scan with prescale:
  - Stimulus: PRESCALE=4, mode down, load 2, then `run`=1.
  - Required response: `sel` steps 2→1→0→31 every 4 cycles; `wrap` at 31.
- Ping-pong reversal:
  - Stimulus: PRESCALE=1, load 29, mode ping-pong, `run`=1.
  - Required response: `sel` 29,30,31,30,29; `wrap` in the cycle `sel`=30 after 31; `dir` down.
- Single-shot end:
  - Stimulus: load 30, mode single-shot, `run`=1.
  - Required response: `sel` 30→31, then DONE with `en`=0, `sel`=31, one `wrap`. `run`=0 then returns to IDLE.
- Stop and load priority:
  - Stimulus: `run` dropped in the same cycle as a tick; separately, `load`=1 with `load_val`=17 coinciding with a tick.
  - Required response: no step in either case; `sel`=17; prescaler restarts.
- Asynchronous reset:
  - Stimulus: assert `rst_n`=0 mid-scan at `sel`=12.
  - Required response: `sel`=0, `en`=0 immediately, without waiting for a clock edge.
